segment_locator: RTL



---
 rtl/seg_loc_pkg.sv | 26 ++
 rtl/abs_conv.sv | 22 ++
 rtl/segment_locator.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_loc_pkg.sv
// ============================================================================
// Module      : seg_loc_pkg
// Description : Shared types and constants for the segment locator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_loc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Breakpoints reset to all-ones; replicated to the breakpoint width at use.
    localparam logic c_BP_RST_BIT = 1'b1;

    // Index width and search depth are both ceil(log2(SEG_NUM+1)).
    function automatic int seg_loc_idx_w(input int seg_num);
        return $clog2(seg_num + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/abs_conv.sv
// ============================================================================
// Module      : abs_conv
// Description : Signed two's-complement to sign + unsigned magnitude.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module abs_conv #(
    parameter int XDW = 16
) (
    input  logic [XDW-1:0] i_x,
    output logic           o_sign,
    output logic [XDW-1:0] o_abs
);

    // Most-negative input maps to 2^(XDW-1), which fits the unsigned result.
    assign o_sign = i_x[XDW-1];
    assign o_abs  = i_x[XDW-1] ? (~i_x + XDW'(1)) : i_x;

endmodule

`default_nettype wire

// File: rtl/segment_locator.sv
// ============================================================================
// Module      : segment_locator
// Description : Binary search of |x| over a programmable breakpoint table.
//               Optional write ordering check: SEG_LOC_MONO_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module segment_locator
    import seg_loc_pkg::*;
#(
    parameter  int XDW     = 16,
    parameter  int SEG_NUM = 8,
    localparam int IDX_W   = seg_loc_idx_w(SEG_NUM),
    localparam int STEPS   = seg_loc_idx_w(SEG_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XDW-1:0]   x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] seg_idx,
    output logic             x_sign,
    output logic [XDW-1:0]   x_abs,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [XDW-1:0]   cfg_data,
    output logic             cfg_err
);

    localparam int               c_DEPTH     = 1 << IDX_W;
    localparam int               c_CNT_W     = $clog2(STEPS + 1);
    localparam logic [IDX_W-1:0] c_SEG_NUM   = IDX_W'(SEG_NUM);
    localparam logic [IDX_W-1:0] c_SEG_LAST  = IDX_W'(SEG_NUM - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(STEPS - 1);
    localparam logic [XDW-1:0]   c_BP_RST    = {XDW{c_BP_RST_BIT}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_in_ready;
    logic               w_out_valid;

    logic [XDW-1:0]     w_bp [c_DEPTH];
    logic [IDX_W-1:0]   r_lo;
    logic [IDX_W-1:0]   r_hi;
    logic [c_CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0]   r_seg_idx;
    logic               r_x_sign;
    logic [XDW-1:0]     r_x_abs;
    logic               r_cfg_err;

    logic               w_sign;
    logic [XDW-1:0]     w_abs;
    logic               w_accept;
    logic               w_last_step;
    logic [IDX_W:0]     w_sum;
    logic [IDX_W-1:0]   w_mid;
    logic [XDW-1:0]     w_bp_mid;
    logic [IDX_W-1:0]   w_lo_nxt;
    logic [IDX_W-1:0]   w_hi_nxt;

    logic               w_cfg_slot;
    logic               w_cfg_addr_ok;
    logic               w_mono_ok;
    logic               w_cfg_wr;

    abs_conv #(
        .XDW (XDW)
    ) u_abs_conv (
        .i_x    (x),
        .o_sign (w_sign),
        .o_abs  (w_abs)
    );

    assign w_accept    = (r_state == IDLE) && in_valid;
    assign w_last_step = (r_cnt == c_LAST_STEP);

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)    w_state_nxt = SEARCH;
            SEARCH:  if (w_last_step) w_state_nxt = DONE;
            DONE:    if (out_ready)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE:    w_in_ready  = 1'b1;
            DONE:    w_out_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Search step: narrows [lo, hi] toward the first bp[k] >= |x|
    // ------------------------------------------------------------------
    assign w_sum    = {1'b0, r_lo} + {1'b0, r_hi};
    assign w_mid    = IDX_W'(w_sum >> 1);
    assign w_bp_mid = w_bp[w_mid];

    always_comb begin
        w_lo_nxt = r_lo;
        w_hi_nxt = r_hi;
        if (r_lo < r_hi) begin
            if (r_x_abs <= w_bp_mid) begin
                w_hi_nxt = w_mid;
            end else begin
                w_lo_nxt = w_mid + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo      <= '0;
            r_hi      <= '0;
            r_cnt     <= '0;
            r_seg_idx <= '0;
            r_x_sign  <= 1'b0;
            r_x_abs   <= '0;
        end else if (w_accept) begin
            r_x_sign <= w_sign;
            r_x_abs  <= w_abs;
            r_lo     <= '0;
            r_hi     <= c_SEG_NUM;
            r_cnt    <= '0;
        end else if (r_state == SEARCH) begin
            r_lo  <= w_lo_nxt;
            r_hi  <= w_hi_nxt;
            r_cnt <= r_cnt + c_CNT_W'(1);
            if (w_last_step) begin
                r_seg_idx <= w_lo_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Configuration writes: only in IDLE with no sample being accepted
    // ------------------------------------------------------------------
    assign w_cfg_slot    = (r_state == IDLE) && !in_valid;
    assign w_cfg_addr_ok = (cfg_addr < c_SEG_NUM);

`ifdef SEG_LOC_MONO_CHECK_EN
    logic [XDW-1:0] w_nb_lo;
    logic [XDW-1:0] w_nb_hi;

    assign w_nb_lo   = w_bp[cfg_addr - IDX_W'(1)];
    assign w_nb_hi   = w_bp[cfg_addr + IDX_W'(1)];
    assign w_mono_ok = ((cfg_addr == '0) || (cfg_data >= w_nb_lo)) &&
                       ((cfg_addr >= c_SEG_LAST) || (cfg_data <= w_nb_hi));
`else
    assign w_mono_ok = 1'b1;
`endif

    assign w_cfg_wr = cfg_we && w_cfg_slot && w_cfg_addr_ok && w_mono_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_cfg_wr;
        end
    end

    // Table padded to a power of two so any IDX_W-bit index is in range;
    // padding entries stay at the reset value.
    for (genvar g = 0; g < c_DEPTH; g++) begin : g_bp
        if (g < SEG_NUM) begin : g_entry
            logic [XDW-1:0] r_bp;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_bp <= c_BP_RST;
                end else if (w_cfg_wr && (cfg_addr == IDX_W'(g))) begin
                    r_bp <= cfg_data;
                end
            end

            assign w_bp[g] = r_bp;
        end else begin : g_pad
            assign w_bp[g] = c_BP_RST;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign seg_idx   = r_seg_idx;
    assign x_sign    = r_x_sign;
    assign x_abs     = r_x_abs;
    assign cfg_err   = r_cfg_err;

endmodule

`default_nettype wire
